// File: rtl/mem_stage_pkg.sv
// Shared types, default parameters and address decoding for the memory stage.
package mem_stage_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned DEST_W_DEF      = 4;
    localparam int unsigned DEPTH_DEF       = 64;
    localparam int unsigned BASE_ADDR_DEF   = 1024;
    localparam int unsigned WAIT_STATES_DEF = 3;

    typedef struct packed {
        logic [31:0] word;
        logic [1:0]  lane;
    } addr_dec_t;

    // Word index is already wrapped modulo depth; depth must be a power of 2.
    function automatic addr_dec_t decode_addr(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input int unsigned depth);
        addr_dec_t dec;
        dec.word = ((addr - base) >> 2) & (depth - 1);
        dec.lane = addr[1:0];
        return dec;
    endfunction

endpackage

// File: rtl/mem_pipe_reg.sv
// MEM/WB pipeline register: hold has priority over bubble, bubble over load.
module mem_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic              bubble_i,
    input  logic              wb_en_i,
    input  logic              mem_r_en_i,
    input  logic [DATA_W-1:0] alu_res_i,
    input  logic [DATA_W-1:0] mem_res_i,
    input  logic [DEST_W-1:0] dest_i,
    output logic              wb_en_o,
    output logic              mem_r_en_o,
    output logic [DATA_W-1:0] alu_res_o,
    output logic [DATA_W-1:0] mem_res_o,
    output logic [DEST_W-1:0] dest_o
);

    logic              wb_en_q;
    logic              mem_r_en_q;
    logic [DATA_W-1:0] alu_res_q;
    logic [DATA_W-1:0] mem_res_q;
    logic [DEST_W-1:0] dest_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            alu_res_q  <= '0;
            mem_res_q  <= '0;
            dest_q     <= '0;
        end else if (!hold_i) begin
            if (bubble_i) begin
                wb_en_q    <= 1'b0;
                mem_r_en_q <= 1'b0;
                alu_res_q  <= '0;
                mem_res_q  <= '0;
                dest_q     <= '0;
            end else begin
                wb_en_q    <= wb_en_i;
                mem_r_en_q <= mem_r_en_i;
                alu_res_q  <= alu_res_i;
                mem_res_q  <= mem_res_i;
                dest_q     <= dest_i;
            end
        end
    end

    assign wb_en_o    = wb_en_q;
    assign mem_r_en_o = mem_r_en_q;
    assign alu_res_o  = alu_res_q;
    assign mem_res_o  = mem_res_q;
    assign dest_o     = dest_q;

endmodule

// File: rtl/mem_wait_stage.sv
// ARM MEM stage: wait-state data memory with word/byte access, stall control and MEM/WB register.
module mem_wait_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned DEST_W      = DEST_W_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
    parameter int unsigned WAIT_STATES = WAIT_STATES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              byte_en_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] mem_res_out,
    output logic [DEST_W-1:0] dest_out,
    output logic              wb_en_hazard,
    output logic [DEST_W-1:0] dest_hazard,
    output logic              ready
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned LANE_W = $clog2(NBYTES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               access;
    logic               commit;

    addr_dec_t          dec;
    logic [IDX_W-1:0]   idx;
    logic [LANE_W-1:0]  lane;
    logic               unused_idx_hi;

    logic [DATA_W-1:0]             mem_q [DEPTH];
    logic [DATA_W-1:0]             rd_word;
    logic [NBYTES-1:0][7:0]        rd_bytes;
    logic [NBYTES-1:0][7:0]        wr_bytes;
    logic [DATA_W-1:0]             load_data;

    assign access = mem_r_en_in | mem_w_en_in;

    assign dec           = decode_addr(32'(alu_res_in), 32'(BASE_ADDR), DEPTH);
    assign idx           = dec.word[IDX_W-1:0];
    assign lane          = LANE_W'(dec.lane);
    assign unused_idx_hi = ^dec.word[31:IDX_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b1;
        case (state_q)
            IDLE: begin
                if (access && WAIT_STATES > 0) begin
                    ready = 1'b0;
                    if (!freeze) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    ready = 1'b0;
                    if (!freeze) cnt_d = cnt_q - CNT_W'(1);
                end else if (!freeze) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit = ready & ~freeze & access;

    // Byte store is a read-modify-write of the addressed word in the same cycle.
    assign rd_word  = mem_q[idx];
    assign rd_bytes = rd_word;

    always_comb begin
        wr_bytes = val_rm_in;
        if (byte_en_in) begin
            wr_bytes       = rd_bytes;
            wr_bytes[lane] = val_rm_in[7:0];
        end
    end

    assign load_data = byte_en_in ? DATA_W'(rd_bytes[lane]) : rd_word;

    // NOTE: the array is deliberately not reset; a reset branch would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (commit && mem_w_en_in && !rst) begin
            mem_q[idx] <= wr_bytes;
        end
    end

    mem_pipe_reg #(
        .DATA_W (DATA_W),
        .DEST_W (DEST_W)
    ) u_pipe_reg (
        .clk        (clk),
        .rst        (rst),
        .hold_i     (freeze),
        .bubble_i   (~ready),
        .wb_en_i    (wb_en_in),
        .mem_r_en_i (mem_r_en_in),
        .alu_res_i  (alu_res_in),
        .mem_res_i  (mem_r_en_in ? load_data : '0),
        .dest_i     (dest_in),
        .wb_en_o    (wb_en_out),
        .mem_r_en_o (mem_r_en_out),
        .alu_res_o  (alu_res_out),
        .mem_res_o  (mem_res_out),
        .dest_o     (dest_out)
    );

    assign wb_en_hazard = wb_en_in;
    assign dest_hazard  = dest_in;

endmodule

// File: tb/tb_mem_wait_stage.sv
// Scoreboard bench for mem_wait_stage: driver queues expected WB results, monitor checks them.
module tb_mem_wait_stage;

    localparam int unsigned WS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        wb_en_in = 1'b0;
    logic        mem_r_en_in = 1'b0;
    logic        mem_w_en_in = 1'b0;
    logic        byte_en_in = 1'b0;
    logic [31:0] alu_res_in = '0;
    logic [31:0] val_rm_in = '0;
    logic [3:0]  dest_in = '0;

    logic        wb_en_out, mem_r_en_out, wb_en_hazard, ready;
    logic [31:0] alu_res_out, mem_res_out;
    logic [3:0]  dest_out, dest_hazard;

    typedef struct {
        logic        wb;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [3:0]  dest;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   active     = 1'b0;
    bit   chk_commit = 1'b0;
    bit   chk_bubble = 1'b0;

    mem_wait_stage #(
        .DATA_W      (32),
        .DEST_W      (4),
        .DEPTH       (64),
        .BASE_ADDR   (1024),
        .WAIT_STATES (WS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .wb_en_in     (wb_en_in),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .byte_en_in   (byte_en_in),
        .alu_res_in   (alu_res_in),
        .val_rm_in    (val_rm_in),
        .dest_in      (dest_in),
        .wb_en_out    (wb_en_out),
        .mem_r_en_out (mem_r_en_out),
        .alu_res_out  (alu_res_out),
        .mem_res_out  (mem_res_out),
        .dest_out     (dest_out),
        .wb_en_hazard (wb_en_hazard),
        .dest_hazard  (dest_hazard),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_word(input logic wb, input logic mr, input logic [3:0] d);
        return {26'b0, wb, mr, d};
    endfunction

    // Monitor: decides at each negedge whether the coming edge commits or bubbles, checks one cycle later.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (chk_commit) begin
            if (exp_q.size() == 0) begin
                check("monitor_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_alu"}, alu_res_out, e.alu);
                check({e.name, "_mem"}, mem_res_out, e.mem);
                check({e.name, "_ctrl"}, ctrl_word(wb_en_out, mem_r_en_out, dest_out),
                      ctrl_word(e.wb, e.mr, e.dest));
            end
        end else if (chk_bubble) begin
            check("bubble", alu_res_out | mem_res_out | ctrl_word(wb_en_out, mem_r_en_out, dest_out),
                  32'h0);
        end
        chk_commit = active && ready && !freeze && !rst;
        chk_bubble = !ready && !freeze && !rst;
    end

    task automatic idle_inputs();
        wb_en_in    = 1'b0;
        mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b0;
        byte_en_in  = 1'b0;
        alu_res_in  = '0;
        val_rm_in   = '0;
        dest_in     = '0;
    endtask

    // Present one instruction at posedge+1, wait for its commit edge, and check the stall length.
    task automatic issue(input string name, input logic wb, input logic r, input logic w,
                         input logic be, input logic [31:0] alu, input logic [31:0] rm,
                         input logic [3:0] dst, input logic [31:0] exp_mem);
        int low  = 0;
        bit done = 1'b0;
        wb_en_in    = wb;
        mem_r_en_in = r;
        mem_w_en_in = w;
        byte_en_in  = be;
        alu_res_in  = alu;
        val_rm_in   = rm;
        dest_in     = dst;
        active      = 1'b1;
        exp_q.push_back('{wb, r, alu, r ? exp_mem : 32'h0, dst, name});
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (c == 0) check({name, "_hazard"}, ctrl_word(wb_en_hazard, 1'b0, dest_hazard),
                              ctrl_word(wb, 1'b0, dst));
            if (!ready) low++;
            else if (!freeze) done = 1'b1;
        end
        if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        active = 1'b0;
        idle_inputs();
        check({name, "_stall"}, low, (r | w) ? WS : 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : driver
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out", alu_res_out | mem_res_out | ctrl_word(wb_en_out, mem_r_en_out, dest_out),
              32'h0);
        check("reset_ready", ready, 1'b1);
        @(posedge clk);
        #1;

        //     name          wb    r     w     be    addr          store data    dst   expected load
        issue("st_word",     1'b0, 1'b0, 1'b1, 1'b0, 32'd1024,     32'hDEADBEEF, 4'd0, 32'h0);
        issue("ld_word",     1'b1, 1'b1, 1'b0, 1'b0, 32'd1024,     32'h0,        4'd3, 32'hDEADBEEF);
        issue("st_base",     1'b0, 1'b0, 1'b1, 1'b0, 32'd1024,     32'h11223344, 4'd0, 32'h0);
        issue("st_byte",     1'b0, 1'b0, 1'b1, 1'b1, 32'd1026,     32'hFFFFFFAB, 4'd0, 32'h0);
        issue("ld_merged",   1'b1, 1'b1, 1'b0, 1'b0, 32'd1024,     32'h0,        4'd1, 32'h11AB3344);
        issue("ldb_1027",    1'b1, 1'b1, 1'b0, 1'b1, 32'd1027,     32'h0,        4'd2, 32'h00000011);
        issue("ldb_1026",    1'b1, 1'b1, 1'b0, 1'b1, 32'd1026,     32'h0,        4'd2, 32'h000000AB);
        issue("ld_unalign",  1'b1, 1'b1, 1'b0, 1'b0, 32'd1027,     32'h0,        4'd4, 32'h11AB3344);
        issue("add",         1'b1, 1'b0, 1'b0, 1'b1, 32'h55,       32'h0,        4'd5, 32'h0);

        // Freeze with a non-memory instruction waiting: the ADD result must stay on the outputs.
        wb_en_in   = 1'b1;
        alu_res_in = 32'h66;
        dest_in    = 4'd6;
        freeze     = 1'b1;
        active     = 1'b1;
        exp_q.push_back('{1'b1, 1'b0, 32'h66, 32'h0, 4'd6, "add_frozen"});
        repeat (2) begin
            @(posedge clk);
            #1;
            check("freeze_hold_alu", alu_res_out, 32'h55);
            check("freeze_hold_ctrl", ctrl_word(wb_en_out, mem_r_en_out, dest_out),
                  ctrl_word(1'b1, 1'b0, 4'd5));
        end
        freeze = 1'b0;
        @(posedge clk);
        #1;
        active = 1'b0;
        idle_inputs();

        // Reset in the middle of a store: the old word must survive and the FSM restart in IDLE.
        issue("st_1028_old", 1'b0, 1'b0, 1'b1, 1'b0, 32'd1028,     32'hCAFEF00D, 4'd8, 32'h0);
        mem_w_en_in = 1'b1;
        alu_res_in  = 32'd1028;
        val_rm_in   = 32'h0BADF00D;
        dest_in     = 4'd8;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_out", alu_res_out | mem_res_out | ctrl_word(wb_en_out, mem_r_en_out, dest_out),
              32'h0);
        check("rst_mid_hazard", ctrl_word(wb_en_hazard, 1'b0, dest_hazard), ctrl_word(1'b0, 1'b0, 4'd8));
        @(posedge clk);
        #1 rst = 1'b0;
        idle_inputs();
        issue("ld_1028",     1'b1, 1'b1, 1'b0, 1'b0, 32'd1028,     32'h0,        4'd9, 32'hCAFEF00D);

        // Freeze while in WAIT with cnt = 0: no commit until freeze drops.
        mem_w_en_in = 1'b1;
        alu_res_in  = 32'd1032;
        val_rm_in   = 32'h77665544;
        dest_in     = 4'd7;
        active      = 1'b1;
        exp_q.push_back('{1'b0, 1'b0, 32'd1032, 32'h0, 4'd7, "st_frozen"});
        repeat (3) @(posedge clk);
        #1 freeze = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("wait_freeze_ready", ready, 1'b1);
            check("wait_freeze_out", alu_res_out | ctrl_word(wb_en_out, mem_r_en_out, dest_out), 32'h0);
            @(posedge clk);
            #1;
        end
        freeze = 1'b0;
        @(posedge clk);
        #1;
        active = 1'b0;
        idle_inputs();
        issue("ld_1032",     1'b1, 1'b1, 1'b0, 1'b0, 32'd1032,     32'h0,        4'd10, 32'h77665544);

        issue("st_wrap",     1'b0, 1'b0, 1'b1, 1'b0, 32'd1280,     32'h00001234, 4'd0, 32'h0);
        issue("ld_wrap",     1'b1, 1'b1, 1'b0, 1'b0, 32'd1024,     32'h0,        4'd11, 32'h00001234);
        issue("st_1036",     1'b0, 1'b0, 1'b1, 1'b0, 32'd1036,     32'h01010101, 4'd0, 32'h0);
        issue("rw_1036",     1'b1, 1'b1, 1'b1, 1'b0, 32'd1036,     32'hA5A5A5A5, 4'd12, 32'h01010101);
        issue("ld_1036",     1'b1, 1'b1, 1'b0, 1'b0, 32'd1036,     32'h0,        4'd13, 32'hA5A5A5A5);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wait_stage.md
# mem_wait_stage

Parametrised memory stage of the ARM pipeline, positioned between EXE and WB. It contains a word-organised data memory with a configurable number of wait states, word and byte access modes, and the MEM/WB pipeline register. When a load or store takes more than one cycle, it drops `ready` so the top level can freeze the upstream stages. It also forwards the incoming destination and write-back enable to the hazard unit.

## Interface
- `DATA_W`, 32: register and data width; must be a multiple of 8.
- `DEST_W`, 4: register-address width.
- `DEPTH`, 64: number of memory words; must be a power of 2.
- `BASE_ADDR`, 1024: byte address that maps to word 0.
- `WAIT_STATES`, 3: extra cycles per memory access, 0..15.

- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `freeze` in 1: external hold of the stage register and the FSM.
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in` in 1: EXE-stage control bits.
- `byte_en_in` in 1: 1 selects a byte access (LDRB/STRB); 0 selects a word access.
- `alu_res_in` in DATA_W: effective address, or the ALU result for non-memory instructions.
- `val_rm_in` in DATA_W: store data.
- `dest_in` in DEST_W: destination register.
- `wb_en_out`, `mem_r_en_out` out 1: registered control bits to WB.
- `alu_res_out`, `mem_res_out` out DATA_W: registered ALU result and load data.
- `dest_out` out DEST_W: registered destination.
- `wb_en_hazard`, `dest_hazard` out 1 / DEST_W: combinational copies of `wb_en_in` and `dest_in`.
- `ready` out 1: 0 while a memory access is stalling the pipeline.

## Operation
- Address mapping: `idx = ((alu_res_in - BASE_ADDR) >> 2) mod DEPTH`; `lane = alu_res_in[1:0]`.
- Memory access: an instruction is a memory access when `mem_r_en_in` or `mem_w_en_in` is 1.
- FSM states: IDLE and WAIT. The counter `cnt` is `$clog2(WAIT_STATES+1)` bits wide.
  - IDLE, access present, `WAIT_STATES > 0`: `ready = 0`. Next state is WAIT with `cnt = WAIT_STATES - 1`.
  - IDLE, access present, `WAIT_STATES == 0`: `ready = 1`. The access commits at this edge.
  - IDLE, no access: `ready = 1`. The instruction passes through.
  - WAIT, `cnt != 0`: `ready = 0`. `cnt` decrements.
  - WAIT, `cnt == 0`: `ready = 1`. The access commits at this edge and the FSM returns to IDLE.
  - `freeze = 1`: the FSM and `cnt` hold, and nothing commits.
- Commit: an access commits on an edge with `ready = 1` and `freeze = 0`.
  - Word store: `mem[idx]` is written with `val_rm_in`.
  - Byte store: only byte `lane` of `mem[idx]` is written, with `val_rm_in[7:0]`. This is a read-modify-write within one cycle.
  - Word load: the load data is `mem[idx]`.
  - Byte load: the load data is byte `lane` of `mem[idx]`, zero-extended. Lanes are little-endian (lane 0 is bits 7:0).
  - The store is performed exactly once per instruction.
- Stage register update, in priority order:
  - `freeze = 1`: hold.
  - `ready = 0`: load a bubble (all register fields 0).
  - Otherwise: load `wb_en_in`, `mem_r_en_in`, `alu_res_in`, the load data (0 for non-loads) and `dest_in`.
- Unused bits: `byte_en_in` is ignored for non-memory instructions. `alu_res_in[1:0]` is ignored for word accesses.
- Simultaneous read and write: if both `mem_r_en_in` and `mem_w_en_in` are 1, the write takes effect and the load data returns the pre-write value.

## Timing
- Reset values: every registered output is 0, `ready` is 1 once inputs are idle, and the FSM is in IDLE with `cnt` = 0. Memory contents are not reset.
- Reset mid-access: the FSM returns to IDLE and the pending store is discarded; the word is unchanged.
- `ready` is combinational from the state and the control inputs. The top level freezes IF/ID/EXE whenever `ready = 0`.
- Non-memory instruction: result appears on the outputs one edge after being presented.
- Memory instruction: `ready` is low for exactly WAIT_STATES cycles. The result appears at the edge after the cycle where `ready` returns to 1, i.e. WAIT_STATES + 1 cycles after presentation.
- Bubbles: WB sees WAIT_STATES bubbles ahead of the load or store.
- Hazard outputs have zero latency and are valid throughout a stall.
- Inputs must stay stable while `ready = 0`, which is guaranteed by the upstream freeze.

## Structure
- Package `mem_stage_pkg`:
  - state enum `{IDLE, WAIT}`;
  - default parameter constants;
  - a function for address-to-index/lane decoding.
- Sub-module `mem_pipe_reg`: parametrised DATA_W/DEST_W register with asynchronous reset, a hold input (`freeze`) and a bubble input (`!ready`).
- The FSM, counter and memory array live in the top module.

## Test plan
- WAIT_STATES=3, word store `0xDEADBEEF` to address 1024, then word load from 1024: `ready` is low for 3 cycles per access; `mem_res_out = 0xDEADBEEF` at cycle 4 of the load; 3 bubbles reach WB before each access.
- Byte store `0xAB` to address 1026 over word `0x11223344`, then word load: result `0x11AB3344`. A byte load from 1027 returns `0x00000011`.
- ADD with `alu_res_in = 0x55`, `wb_en_in = 1`: `ready` stays 1; `alu_res_out = 0x55` and `wb_en_out = 1` after one edge.
- Assert `rst` during cycle 2 of a store to 1028: outputs go to 0 and the FSM is in IDLE; a subsequent word load from 1028 returns the old value.
- Hold `freeze` for 2 cycles while the FSM is in WAIT with `cnt = 0`: no commit, registered outputs held; the commit occurs on the first edge after `freeze` falls, and the store is written once.
- DEPTH=64, word store `0x1234` to address 1024+256: reading address 1024 returns `0x1234` (wrap-around).
